load_memory_control_unit: RTL and testbench
===========================================

Name: load_memory_control_unit

Overview:
- Read-side counterpart of the store memory control unit in the MEM stage.
- Accepts a load request (funct3 plus low address bits) and checks alignment and encoding.
- Issues a one-cycle read request to data memory and waits for a variable-latency response, with a timeout.
- Extracts the addressed byte, halfword or word from the returned 32-bit word, sign- or zero-extends it, and returns it to writeback with a valid pulse. Stalls the pipeline while the access is outstanding.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles before abandoning the read; legal range 2..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- is_load  in  1  load instruction present in MEM stage this cycle.
- funct3  in  3  RV32I load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- bit_address  in  2  address bits [1:0]; byte offset within the word.
- mem_rdata  in  32  word returned by data memory.
- mem_rvalid  in  1  mem_rdata valid this cycle.
- mem_req  out  1  one-cycle read request pulse to data memory.
- stall  out  1  hold upstream pipeline stages.
- load_data_out  out  32  aligned, extended load result.
- load_valid  out  1  one-cycle pulse; load_data_out is valid.
- load_fault  out  1  one-cycle pulse; load aborted.
- fault_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout; held until the next fault.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0, captured funct3/offset=0. Outputs: mem_req=0, load_valid=0, load_fault=0, fault_cause=00, load_data_out=0. stall=0 because it is decoded from state.
- States: IDLE, WAIT. There is no separate done state; results register on the edge that leaves WAIT.
- IDLE, is_load=1, legal and aligned:
  - capture funct3 and bit_address;
  - assert mem_req (registered, high exactly one cycle after the capture edge);
  - clear counter; go to WAIT.
- Legal and aligned means:
  - LB/LBU: any offset;
  - LH/LHU: offset[0]=0;
  - LW: offset=00.
- IDLE, is_load=1, funct3 in {011,110,111}: no mem_req; load_fault=1 next cycle; fault_cause=10; stay IDLE.
- IDLE, is_load=1, legal but misaligned: no mem_req; load_fault=1 next cycle; fault_cause=01; stay IDLE.
- If a load is both illegal and misaligned, the illegal-funct3 fault (10) takes priority.
- stall (combinational) = (state==WAIT) OR (state==IDLE AND is_load AND legal AND aligned). It is therefore high from the request cycle through the final WAIT cycle.
- WAIT, mem_rvalid=1:
  - load_data_out registers the extracted value; load_valid=1 the following cycle; go to IDLE.
- Extraction (lanes selected by captured offset):
  - LB/LBU: byte lane offset, mem_rdata[8*off+7:8*off]; LB sign-extends bit 7, LBU zero-fills.
  - LH/LHU: offset 00 → [15:0], offset 10 → [31:16]; LH sign-extends bit 15, LHU zero-fills.
  - LW: mem_rdata unchanged.
- WAIT, mem_rvalid=0: counter increments. When counter reaches TIMEOUT-1 with no rvalid:
  - load_fault=1 next cycle, fault_cause=11;
  - load_data_out keeps its previous value; go to IDLE.
- If mem_rvalid arrives in the same cycle the counter reaches TIMEOUT-1, mem_rvalid wins: normal completion, no fault.
- is_load asserted during WAIT is ignored; upstream holds it under stall and it is re-sampled in IDLE.
- mem_rvalid in IDLE is ignored; no output changes.
- load_data_out holds its value between loads; it changes only on a completing load.
- Back-to-back loads: minimum spacing is request edge → WAIT → completion → IDLE. A new request is accepted in the cycle load_valid is high.
- Reset asserted mid-WAIT: return immediately to reset values; the outstanding mem_rvalid is dropped.

Test Plan:
- LB offset 11, mem_rdata=32'h80FF_1234, rvalid 3 cycles after mem_req → load_data_out=32'hFFFF_FF80, load_valid one cycle, stall high throughout the access.
- LHU offset 10, mem_rdata=32'h8001_7FFF, rvalid 1 cycle after mem_req → load_data_out=32'h0000_8001; LH with the same stimulus → 32'hFFFF_8001.
- LW offset 01 → no mem_req, load_fault pulse, fault_cause=01, stall never high. funct3=011 offset 00 → fault_cause=10.
- LW with rvalid never asserted, TIMEOUT=16 → load_fault pulse with fault_cause=11 16 cycles after entering WAIT; load_data_out unchanged; next LW, mem_rdata=32'hDEAD_BEEF → 32'hDEAD_BEEF.
- rst_n pulsed low during WAIT, then rvalid=1 → all outputs 0, state IDLE, no load_valid.
- Two consecutive LBU loads, the second held under stall → two mem_req pulses and two load_valid pulses. Offsets 00 and 01 on mem_rdata=32'h0000_AB12 → 32'h0000_0012 then 32'h0000_00AB.

Source files
------------

// File: rtl/load_memory_control_unit.sv
// MEM-stage load controller: validates a load, issues a one-cycle read request,
// waits (bounded) for the memory response and returns the aligned, extended result.
module load_memory_control_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_load,
  input  logic [2:0]  funct3,
  input  logic [1:0]  bit_address,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_req,
  output logic        stall,
  output logic [31:0] load_data_out,
  output logic        load_valid,
  output logic        load_fault,
  output logic [1:0]  fault_cause
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic        legal;
  logic        aligned;
  logic        accept;
  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] extracted;

  // Request decode: legal funct3 encodings and natural alignment for the size.
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b0;
    case (funct3)
      3'b000, 3'b100: begin legal = 1'b1; aligned = 1'b1; end
      3'b001, 3'b101: begin legal = 1'b1; aligned = ~bit_address[0]; end
      3'b010:         begin legal = 1'b1; aligned = (bit_address == 2'b00); end
      default:        begin legal = 1'b0; aligned = 1'b0; end
    endcase
  end

  assign accept = (state == IDLE) && is_load && legal && aligned;
  assign stall  = (state == WAIT) || accept;

  // Lane extraction uses the captured offset; funct3[2] selects zero-fill.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   extracted = {{24{~f3_q[2] & byte_v[7]}}, byte_v};
      2'b01:   extracted = {{16{~f3_q[2] & half_v[15]}}, half_v};
      default: extracted = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      mem_req       <= 1'b0;
      load_valid    <= 1'b0;
      load_fault    <= 1'b0;
      fault_cause   <= 2'b00;
      load_data_out <= 32'h0;
    end else begin
      mem_req    <= 1'b0;
      load_valid <= 1'b0;
      load_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (is_load) begin
            if (!legal) begin
              load_fault  <= 1'b1;
              fault_cause <= CAUSE_ILLEGAL;
            end else if (!aligned) begin
              load_fault  <= 1'b1;
              fault_cause <= CAUSE_MISALIGNED;
            end else begin
              f3_q    <= funct3;
              off_q   <= bit_address;
              mem_req <= 1'b1;
              cnt     <= '0;
              state   <= WAIT;
            end
          end
        end
        default: begin
          // A response on the final allowed cycle still completes normally.
          if (mem_rvalid) begin
            load_data_out <= extracted;
            load_valid    <= 1'b1;
            state         <= IDLE;
          end else if (cnt == CNT_LAST) begin
            load_fault  <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_memory_control_unit.sv
// Directed bench for load_memory_control_unit: drivers push expected completions
// into a queue, a negedge monitor pops and compares on every valid/fault pulse.
module tb_load_memory_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        is_load = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [1:0]  bit_address = 2'b00;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_rvalid = 1'b0;
  logic        mem_req;
  logic        stall;
  logic [31:0] load_data_out;
  logic        load_valid;
  logic        load_fault;
  logic [1:0]  fault_cause;

  load_memory_control_unit #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .is_load       (is_load),
    .funct3        (funct3),
    .bit_address   (bit_address),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .mem_req       (mem_req),
    .stall         (stall),
    .load_data_out (load_data_out),
    .load_valid    (load_valid),
    .load_fault    (load_fault),
    .fault_cause   (fault_cause)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          req_cnt = 0;
  logic [33:0] exp_q[$];
  logic [31:0] last_data = 32'h0;
  logic [33:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry tag 00 = data completion, otherwise the expected fault cause.
  task automatic push_valid(input logic [31:0] d);
    exp_q.push_back({2'b00, d});
    last_data = d;
  endtask

  task automatic push_fault(input logic [1:0] c);
    exp_q.push_back({c, last_data});
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mem_req) req_cnt++;
    if (rst_n && (load_valid || load_fault)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: valid=%b fault=%b data=%h cause=%b",
                 load_valid, load_fault, load_data_out, fault_cause);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[33:32] == 2'b00) begin
          check("valid_pulse", 32'(load_valid), 32'd1);
          check("no_fault_on_valid", 32'(load_fault), 32'd0);
          check("load_data", load_data_out, mon_e[31:0]);
        end else begin
          check("fault_pulse", 32'(load_fault), 32'd1);
          check("no_valid_on_fault", 32'(load_valid), 32'd0);
          check("fault_cause", 32'(fault_cause), 32'(mon_e[33:32]));
          check("data_hold_on_fault", load_data_out, mon_e[31:0]);
        end
      end
    end
  end

  // Legal aligned load; rvalid arrives lat cycles after the mem_req cycle.
  task automatic do_load(input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] rdata, input int lat, input logic [31:0] exp_d);
    push_valid(exp_d);
    is_load = 1'b1; funct3 = f3; bit_address = off;
    @(negedge clk);
    check("stall_on_request", 32'(stall), 32'd1);
    tick();
    is_load = 1'b0;
    for (int i = 0; i <= lat; i++) begin
      if (i == lat) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
      end
      @(negedge clk);
      check("mem_req_shape", 32'(mem_req), 32'(i == 0));
      check("stall_in_wait", 32'(stall), 32'd1);
      tick();
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("stall_after_done", 32'(stall), 32'd0);
    tick();
  endtask

  // Rejected load: fault expected, no request, no stall.
  task automatic do_bad(input logic [2:0] f3, input logic [1:0] off, input logic [1:0] cause);
    push_fault(cause);
    req_cnt = 0;
    is_load = 1'b1; funct3 = f3; bit_address = off;
    @(negedge clk);
    check("no_stall_on_reject", 32'(stall), 32'd0);
    tick();
    is_load = 1'b0;
    @(negedge clk);
    check("no_stall_after_reject", 32'(stall), 32'd0);
    tick();
    check("no_mem_req_on_reject", 32'(req_cnt), 32'd0);
  endtask

  int cyc;

  initial begin
    // Reset
    tick(); tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_data", load_data_out, 32'h0);
    check("rst_valid", 32'(load_valid), 32'd0);
    check("rst_fault", 32'(load_fault), 32'd0);
    check("rst_cause", 32'(fault_cause), 32'd0);
    rst_n = 1'b1;
    tick();

    // Sign/zero extension across lanes
    do_load(3'b000, 2'b11, 32'h80FF_1234, 3, 32'hFFFF_FF80);
    do_load(3'b101, 2'b10, 32'h8001_7FFF, 1, 32'h0000_8001);
    do_load(3'b001, 2'b10, 32'h8001_7FFF, 1, 32'hFFFF_8001);
    do_load(3'b100, 2'b11, 32'h80FF_1234, 0, 32'h0000_0080);
    do_load(3'b001, 2'b00, 32'h1234_8765, 2, 32'hFFFF_8765);

    // Misaligned, illegal, and illegal-over-misaligned priority
    do_bad(3'b010, 2'b01, 2'b01);
    do_bad(3'b011, 2'b00, 2'b10);
    do_bad(3'b110, 2'b01, 2'b10);
    do_bad(3'b101, 2'b11, 2'b01);

    // Timeout after 16 WAIT cycles, then recovery
    push_fault(2'b11);
    is_load = 1'b1; funct3 = 3'b010; bit_address = 2'b00;
    tick();
    is_load = 1'b0;
    cyc = 0;
    while (cyc < 40 && !load_fault) begin
      tick();
      cyc++;
    end
    check("timeout_latency", 32'(cyc), 32'd16);
    tick();
    do_load(3'b010, 2'b00, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);
    check("cause_held", 32'(fault_cause), 32'd3);

    // rvalid on the last allowed cycle wins over the timeout
    do_load(3'b010, 2'b00, 32'h1234_5678, 15, 32'h1234_5678);

    // Reset asserted mid-WAIT drops the outstanding access
    is_load = 1'b1; funct3 = 3'b010; bit_address = 2'b00;
    tick();
    is_load = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_data", load_data_out, 32'h0);
    check("midrst_cause", 32'(fault_cause), 32'd0);
    tick();
    rst_n = 1'b1;
    last_data = 32'h0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    tick();
    mem_rvalid = 1'b0;
    check("postrst_valid", 32'(load_valid), 32'd0);
    check("postrst_data", load_data_out, 32'h0);
    check("postrst_stall", 32'(stall), 32'd0);
    tick();

    // Back-to-back LBU, the second held on is_load under stall
    req_cnt = 0;
    push_valid(32'h0000_0012);
    push_valid(32'h0000_00AB);
    is_load = 1'b1; funct3 = 3'b100; bit_address = 2'b00;
    tick();
    bit_address = 2'b01;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_AB12;
    @(negedge clk);
    check("b2b_stall_wait", 32'(stall), 32'd1);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("b2b_stall_reissue", 32'(stall), 32'd1);
    tick();
    is_load = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    tick();
    tick();
    check("b2b_req_count", 32'(req_cnt), 32'd2);

    // Drain and report
    repeat (4) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
